// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the default datapath width.
package divider_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One combinational radix-2 restoring iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor magnitude if it fits.
module divider_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor_mag,
    input  logic             next_bit,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;

    // The incoming remainder is always below divisor_mag, so after the
    // subtract (or without it) the result fits back into WIDTH bits.
    always_comb begin
        shifted_s = {rem, next_bit};
        if (shifted_s >= {1'b0, divisor_mag}) begin
            q_bit   = 1'b1;
            new_rem = WIDTH'(shifted_s - {1'b0, divisor_mag});
        end else begin
            q_bit   = 1'b0;
            new_rem = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both
// sides; signed operation divides magnitudes and fixes signs at the end.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dmag_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] final_q_s;

    assign accept_s   = in_valid & in_ready_r;
    assign zero_div_s = (divisor == {WIDTH{1'b0}});
    assign dvd_neg_s  = is_signed & dividend[WIDTH-1];
    assign dvs_neg_s  = is_signed & divisor[WIDTH-1];
    assign dvd_mag_s  = dvd_neg_s ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag_s  = dvs_neg_s ? (~divisor + WIDTH'(1)) : divisor;
    assign final_q_s  = {quo_r[WIDTH-2:0], step_q_s};

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_r),
        .divisor_mag (dmag_r),
        .next_bit    (quo_r[WIDTH-1]),
        .new_rem     (step_rem_s),
        .q_bit       (step_q_s)
    );

    // Next-state decode; a zero divisor skips CALC entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (accept_s) begin
                    state_next_s = zero_div_s ? DIV_DONE : DIV_CALC;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                if (count_r == {CW{1'b0}}) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_CALC;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_next_s = DIV_IDLE;
                end else begin
                    state_next_s = DIV_DONE;
                end
            end
            default: state_next_s = DIV_IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= DIV_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == DIV_IDLE);
            out_valid_r <= (state_next_s == DIV_DONE);
        end
    end

    // Operand capture, iteration and sign fix-up of the final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= {CW{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            dmag_r      <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (accept_s && zero_div_s) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dividend;
                        dbz_r       <= 1'b1;
                    end else if (accept_s) begin
                        rem_r   <= {WIDTH{1'b0}};
                        quo_r   <= dvd_mag_s;
                        dmag_r  <= dvs_mag_s;
                        neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                        neg_r_r <= dvd_neg_s;
                        count_r <= CW'(WIDTH - 1);
                        dbz_r   <= 1'b0;
                    end else begin
                        count_r <= count_r;
                    end
                end
                DIV_CALC: begin
                    rem_r   <= step_rem_s;
                    quo_r   <= final_q_s;
                    count_r <= count_r - CW'(1);
                    if (count_r == {CW{1'b0}}) begin
                        // MIN / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
                        quotient_r  <= neg_q_r ? (~final_q_s + WIDTH'(1)) : final_q_s;
                        remainder_r <= neg_r_r ? (~step_rem_s + WIDTH'(1)) : step_rem_s;
                    end else begin
                        quotient_r  <= quotient_r;
                    end
                end
                DIV_DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
